spi_io_tx_queue: RTL
====================

Name: spi_io_tx_queue

Overview:
- Buffers CPU memory-bus writes destined for the SPI I/O unit, so firmware can post several words without polling the busy flag between them.
- Sits between the CPU data-memory bus and spi_io.
- Accepts posted words at its own bus address and holds them in a FIFO.
- Drains the FIFO to spi_io one word at a time, issuing a write strobe only when spi_io reports not-busy.

Parameters:
- DEPTH, 4: FIFO entries. Power of two, 2..16.
- QUEUE_ADDR, 32'h80000004: bus address the CPU writes to and reads status from.
- SPI_IO_ADDR, 32'h80000000: address presented to spi_io on drain strobes.

Ports:
- clk  in  1  system clock.
- rstn  in  1  asynchronous active-low reset.
- mem_bus_addr  in  32  CPU bus address.
- mem_bus_data  in  32  CPU write data.
- mem_bus_write_en  in  1  CPU write strobe.
- mem_bus_data_mask  in  2  byte-count code: 01=1 byte, 10=2 bytes, 11=4 bytes, 00=none.
- mem_bus_read_en  in  1  CPU read strobe.
- mem_bus_queue_status  out  8  status byte (bit map below).
- mem_bus_queue_status_write_en  out  1  high when addr==QUEUE_ADDR && read_en; status takes precedence over data memory.
- spi_addr  out  32  address to spi_io.
- spi_data  out  32  word to spi_io.
- spi_write_en  out  1  one-cycle drain strobe.
- spi_data_mask  out  2  mask of the drained entry.
- spi_status  in  8  spi_io status; bit0 = busy.

Behaviour:
- Clock and reset: single clock clk. Reset rstn is asynchronous and active-low. All flops clear immediately on rstn low.
- Reset values: FIFO empty, count 0, overflow 0, state IDLE, spi_addr 0, spi_data 0, spi_write_en 0, spi_data_mask 0.
- Enqueue condition: addr==QUEUE_ADDR && write_en && mask!=00 && !full. The entry {mask, data} (34 bits) is written at the clock edge.
- Writes with mask 00 are ignored silently; they do not enqueue and do not set overflow.
- Enqueue while full: word dropped, overflow flag set (sticky).
- full is evaluated on the pre-edge count. A same-cycle pop does not free a slot for a same-cycle push.
- Status byte:
  - bit0 full.
  - bit1 empty.
  - bit2 overflow.
  - bits7:3 count, zero-extended to 5 bits.
  - The byte is combinational, valid every cycle.
- Overflow clear: overflow clears on the edge of any cycle in which status_write_en=1. If a dropped write coincides with that clear, set wins.
- Drain FSM states: IDLE, ISSUE, HOLD, WAIT.
  - IDLE: if !empty && spi_status[0]==0, go to ISSUE. Head entry is loaded into spi_data/spi_data_mask, spi_addr is set to SPI_IO_ADDR, and the entry is popped.
  - ISSUE: spi_write_en=1 for exactly this cycle, then go to HOLD.
  - HOLD: one cycle with spi_write_en=0, ignoring busy, to cover spi_io's state update latency. Then go to WAIT.
  - WAIT: stay until spi_status[0]==0, then go to IDLE.
  - spi_addr returns to 0 whenever the FSM is not in ISSUE.
- Latency: with an empty queue and idle spi_io, a bus write in cycle 0 produces the spi_write_en pulse in cycle 2. Back-to-back words are separated by at least spi_io's full transfer time plus 3 cycles.
- Simultaneous push and pop with count not full: both occur and count is unchanged. Pop and push pointers wrap modulo DEPTH.
- Reset mid-drain: FIFO flushes, strobe deasserts, FSM returns to IDLE. Words in flight in spi_io are not tracked.

Decomposition:
- Package spi_io_pkg holds:
  - drain_state_t enum (IDLE, ISSUE, HOLD, WAIT).
  - Status bit indices STAT_FULL=0, STAT_EMPTY=1, STAT_OVF=2, STAT_CNT_LSB=3.
  - Mask code constants.
- One sub-module: sync_fifo, parameterised on WIDTH=34 and DEPTH. It provides push, pop, head, count, full and empty, with asynchronous active-low reset.

Test Plan:
1. Reset, then write 32'hA5A5_1234 with mask 11 at QUEUE_ADDR; spi_io idle. Expect: spi_write_en pulses once in cycle 2, spi_data=A5A51234, mask=11, addr=80000000; status reads empty=1, count=0 afterwards.
2. DEPTH=4, five back-to-back writes (values 1..5, mask 01) while busy is held high. Expect: count=4, full=1, overflow=1, fifth word lost. After busy releases, four strobes carry 1,2,3,4 in order, each separated by a WAIT.
3. Write with mask 00. Expect: no enqueue, count stays 0, no strobe, overflow 0.
4. Set overflow, then issue a status read at QUEUE_ADDR. Expect: status_write_en=1 that cycle with bit2=1; the next read shows bit2=0.
5. Queue holds 2 entries and spi_io is idle. Push a third word in the same cycle the FSM pops. Expect: count stays 2, and FIFO order is preserved across pointer wrap.
6. Assert rstn low during HOLD with 3 entries queued. Expect: outputs zero immediately without waiting for a clock edge, empty=1 after release, no further strobes.

Source files
------------

// File: rtl/spi_io_pkg.sv
// Shared types and constants for the SPI I/O transmit queue.
// Holds the drain FSM state type, status bit positions and mask codes.
package spi_io_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        HOLD  = 2'd2,
        WAIT  = 2'd3
    } drain_state_t;

    localparam int STAT_FULL    = 0;
    localparam int STAT_EMPTY   = 1;
    localparam int STAT_OVF     = 2;
    localparam int STAT_CNT_LSB = 3;

    localparam logic [1:0] MASK_NONE = 2'b00;
    localparam logic [1:0] MASK_BYTE = 2'b01;
    localparam logic [1:0] MASK_HALF = 2'b10;
    localparam logic [1:0] MASK_WORD = 2'b11;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with occupancy count, asynchronous active-low reset.
// Ports: clk, rstn, push/din in, pop in, head/count/full/empty out.
module sync_fifo #(
    parameter  int WIDTH = 34,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Guards use the pre-edge count, so a pop never frees a slot
    // for a push in the same cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/spi_io_tx_queue.sv
// Posted-write queue between the CPU data bus and spi_io.
// Ports: mem_bus_* CPU side (write/read strobes, status byte out),
// spi_* drain side (addr/data/mask/strobe out, spi_status busy in).
module spi_io_tx_queue
    import spi_io_pkg::*;
#(
    parameter int          DEPTH       = 4,
    parameter logic [31:0] QUEUE_ADDR  = 32'h8000_0004,
    parameter logic [31:0] SPI_IO_ADDR = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] mem_bus_addr,
    input  logic [31:0] mem_bus_data,
    input  logic        mem_bus_write_en,
    input  logic [1:0]  mem_bus_data_mask,
    input  logic        mem_bus_read_en,
    output logic [7:0]  mem_bus_queue_status,
    output logic        mem_bus_queue_status_write_en,
    output logic [31:0] spi_addr,
    output logic [31:0] spi_data,
    output logic        spi_write_en,
    output logic [1:0]  spi_data_mask,
    input  logic [7:0]  spi_status
);

    localparam int CW = $clog2(DEPTH) + 1;

    drain_state_t  state;
    logic          overflow;
    logic          push_req;
    logic          pop;
    logic [33:0]   head;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic          spi_busy;
    logic          unused_status;

    assign spi_busy      = spi_status[0];
    assign unused_status = ^spi_status[7:1];

    assign push_req = (mem_bus_addr == QUEUE_ADDR) && mem_bus_write_en
                   && (mem_bus_data_mask != MASK_NONE);
    assign pop      = (state == IDLE) && !empty && !spi_busy;

    assign mem_bus_queue_status_write_en =
        (mem_bus_addr == QUEUE_ADDR) && mem_bus_read_en;

    sync_fifo #(
        .WIDTH (34),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (push_req),
        .din   ({mem_bus_data_mask, mem_bus_data}),
        .pop   (pop),
        .head  (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    always_comb begin
        mem_bus_queue_status                 = '0;
        mem_bus_queue_status[STAT_FULL]      = full;
        mem_bus_queue_status[STAT_EMPTY]     = empty;
        mem_bus_queue_status[STAT_OVF]       = overflow;
        mem_bus_queue_status[7:STAT_CNT_LSB] = 5'(count);
    end

    // A dropped write in the same cycle as a status read keeps the flag set.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            overflow <= 1'b0;
        end else if (push_req && full) begin
            overflow <= 1'b1;
        end else if (mem_bus_queue_status_write_en) begin
            overflow <= 1'b0;
        end
    end

    // Strobe and address are registered on entry to ISSUE so they are
    // high for exactly the ISSUE cycle; HOLD masks spi_io's busy latency.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state         <= IDLE;
            spi_addr      <= '0;
            spi_data      <= '0;
            spi_write_en  <= 1'b0;
            spi_data_mask <= '0;
        end else begin
            spi_write_en <= 1'b0;
            spi_addr     <= '0;
            unique case (state)
                IDLE: begin
                    if (pop) begin
                        state         <= ISSUE;
                        spi_write_en  <= 1'b1;
                        spi_addr      <= SPI_IO_ADDR;
                        spi_data      <= head[31:0];
                        spi_data_mask <= head[33:32];
                    end
                end
                ISSUE: state <= HOLD;
                HOLD:  state <= WAIT;
                WAIT: begin
                    if (!spi_busy) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
